// File: rtl/if_instr_queue.sv
// if_instr_queue: fetch-to-decode circular instruction queue with one-cycle flush.
// Define IFQ_BYPASS_EN to let an empty queue pass fetch straight through to the IF_* outputs.
module if_instr_queue #(
   parameter int DEPTH  = 4,
   parameter int EXC_W  = 4,
   parameter int PRED_W = 34
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       IF_Flush,
   input  logic                       Fetch_Valid,
   output logic                       Fetch_Ready,
   input  logic [31:0]                Fetch_Instr,
   input  logic [31:0]                Fetch_PC,
   input  logic [EXC_W-1:0]           Fetch_ExceptType,
   input  logic [PRED_W-1:0]          Fetch_PResult,
   input  logic                       ID_Wr,
   output logic                       IF_Valid,
   output logic [31:0]                IF_Instr,
   output logic [31:0]                IF_PC,
   output logic [EXC_W-1:0]           IF_ExceptType,
   output logic [PRED_W-1:0]          IF_PResult,
   output logic [$clog2(DEPTH):0]     IFQ_Count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]       instr_q [DEPTH];
   logic [31:0]       pc_q    [DEPTH];
   logic [EXC_W-1:0]  exc_q   [DEPTH];
   logic [PRED_W-1:0] pred_q  [DEPTH];
   logic [AW-1:0]     rd_ptr, wr_ptr;
   logic [CW-1:0]     count;
   logic              stored, byp, push, pop;

   assign stored      = count != '0;
   assign Fetch_Ready = count < CW'(DEPTH);
`ifdef IFQ_BYPASS_EN
   assign byp = !stored && Fetch_Valid && !IF_Flush;
`else
   assign byp = 1'b0;
`endif
   assign IF_Valid  = stored || byp;
   assign pop       = stored && ID_Wr && !IF_Flush;
   // a bypassed entry taken by ID this cycle is never stored
   assign push      = Fetch_Valid && Fetch_Ready && !IF_Flush && !(byp && ID_Wr);
   assign IFQ_Count = count;

   always_comb begin
      IF_Instr      = stored ? instr_q[rd_ptr] : byp ? Fetch_Instr      : '0;
      IF_PC         = stored ? pc_q[rd_ptr]    : byp ? Fetch_PC         : '0;
      IF_ExceptType = stored ? exc_q[rd_ptr]   : byp ? Fetch_ExceptType : '0;
      IF_PResult    = stored ? pred_q[rd_ptr]  : byp ? Fetch_PResult    : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (IF_Flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + AW'(pop);
         wr_ptr <= wr_ptr + AW'(push);
         count  <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_q[wr_ptr] <= Fetch_Instr;
         pc_q[wr_ptr]    <= Fetch_PC;
         exc_q[wr_ptr]   <= Fetch_ExceptType;
         pred_q[wr_ptr]  <= Fetch_PResult;
      end
   end
endmodule

// File: tb/tb_if_instr_queue.sv
// tb_if_instr_queue: directed checks of ordering, full/flush/reset behaviour and field transport.
module tb_if_instr_queue;
   logic        clk = 1'b0;
   logic        rst, IF_Flush, Fetch_Valid, Fetch_Ready, ID_Wr, IF_Valid;
   logic [31:0] Fetch_Instr, Fetch_PC, IF_Instr, IF_PC;
   logic [3:0]  Fetch_ExceptType, IF_ExceptType;
   logic [33:0] Fetch_PResult, IF_PResult;
   logic [2:0]  IFQ_Count;
   int          passed = 0, total = 0;

   if_instr_queue dut (
      .clk(clk), .rst(rst), .IF_Flush(IF_Flush), .Fetch_Valid(Fetch_Valid),
      .Fetch_Ready(Fetch_Ready), .Fetch_Instr(Fetch_Instr), .Fetch_PC(Fetch_PC),
      .Fetch_ExceptType(Fetch_ExceptType), .Fetch_PResult(Fetch_PResult), .ID_Wr(ID_Wr),
      .IF_Valid(IF_Valid), .IF_Instr(IF_Instr), .IF_PC(IF_PC), .IF_ExceptType(IF_ExceptType),
      .IF_PResult(IF_PResult), .IFQ_Count(IFQ_Count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      IF_Flush = 1'b0;
      Fetch_Valid = 1'b0;
      ID_Wr = 1'b0;
      Fetch_Instr = '0;
      Fetch_PC = '0;
      Fetch_ExceptType = '0;
      Fetch_PResult = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (IF_Valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", IF_Valid); else passed++;
      total++; if (Fetch_Ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", Fetch_Ready); else passed++;
      total++; if (IFQ_Count !== 3'd0) $display("FAIL reset_count got %0d want 0", IFQ_Count); else passed++;
      total++; if ({IF_Instr, IF_PC, IF_ExceptType, IF_PResult} !== '0)
         $display("FAIL reset_data got %h/%h/%h/%h want 0", IF_Instr, IF_PC, IF_ExceptType, IF_PResult); else passed++;
   endtask

   task automatic test_stream();
      logic [31:0] pcs [3] = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008};
      do_reset();
      ID_Wr = 1'b1;
      Fetch_Valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         Fetch_PC = pcs[i];
         Fetch_Instr = 32'h1000 + i;
`ifdef IFQ_BYPASS_EN
         #1;
         total++; if (IF_Valid !== 1'b1 || IF_PC !== pcs[i])
            $display("FAIL stream_byp%0d got %0b/%h want 1/%h", i, IF_Valid, IF_PC, pcs[i]); else passed++;
         step();
         total++; if (IFQ_Count !== 3'd0) $display("FAIL stream_cnt%0d got %0d want 0", i, IFQ_Count); else passed++;
`else
         if (i == 0) begin
            #1;
            total++; if (IF_Valid !== 1'b0) $display("FAIL stream_early got %0b want 0", IF_Valid); else passed++;
         end
         step();
         total++; if (IF_Valid !== 1'b1 || IF_PC !== pcs[i])
            $display("FAIL stream_pc%0d got %0b/%h want 1/%h", i, IF_Valid, IF_PC, pcs[i]); else passed++;
         total++; if (IFQ_Count !== 3'd1) $display("FAIL stream_cnt%0d got %0d want 1", i, IFQ_Count); else passed++;
`endif
      end
      Fetch_Valid = 1'b0;
      step();
      total++; if (IF_Valid !== 1'b0 || IFQ_Count !== 3'd0)
         $display("FAIL stream_drain got %0b/%0d want 0/0", IF_Valid, IFQ_Count); else passed++;
   endtask

   task automatic test_full();
      logic [31:0] base = 32'h00400000;
      do_reset();
      Fetch_Valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         Fetch_PC = base + 32'(4 * i);
         step();
      end
      total++; if (IFQ_Count !== 3'd4 || Fetch_Ready !== 1'b0)
         $display("FAIL full_state got %0d/%0b want 4/0", IFQ_Count, Fetch_Ready); else passed++;
      Fetch_PC = base + 32'd16;
      step();
      total++; if (IFQ_Count !== 3'd4 || IF_PC !== base)
         $display("FAIL full_hold got %0d/%h want 4/%h", IFQ_Count, IF_PC, base); else passed++;
      ID_Wr = 1'b1;
      #1;
      total++; if (Fetch_Ready !== 1'b0) $display("FAIL full_no_idwr_path got %0b want 0", Fetch_Ready); else passed++;
      step();
      total++; if (IFQ_Count !== 3'd3 || Fetch_Ready !== 1'b1 || IF_PC !== base + 32'd4)
         $display("FAIL full_pop1 got %0d/%0b/%h want 3/1/%h", IFQ_Count, Fetch_Ready, IF_PC, base + 32'd4); else passed++;
      step();
      Fetch_Valid = 1'b0;
      total++; if (IFQ_Count !== 3'd3 || IF_PC !== base + 32'd8)
         $display("FAIL full_pop2 got %0d/%h want 3/%h", IFQ_Count, IF_PC, base + 32'd8); else passed++;
      for (int i = 3; i < 5; i++) begin
         step();
         total++; if (IF_PC !== base + 32'(4 * i) || IFQ_Count !== 3'(5 - i))
            $display("FAIL full_pop%0d got %h/%0d want %h/%0d", i, IF_PC, IFQ_Count, base + 32'(4 * i), 5 - i); else passed++;
      end
      step();
      total++; if (IF_Valid !== 1'b0) $display("FAIL full_empty got %0b want 0", IF_Valid); else passed++;
   endtask

   task automatic test_flush();
      do_reset();
      Fetch_Valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         Fetch_PC = 32'h100 + 32'(i);
         Fetch_Instr = 32'hA0 + 32'(i);
         step();
      end
      total++; if (IFQ_Count !== 3'd3) $display("FAIL flush_pre got %0d want 3", IFQ_Count); else passed++;
      IF_Flush = 1'b1;
      ID_Wr = 1'b1;
      Fetch_PC = 32'hDEAD0000;
      Fetch_Instr = 32'hDEADBEEF;
      step();
      IF_Flush = 1'b0;
      ID_Wr = 1'b0;
      Fetch_Valid = 1'b0;
      #1;
      total++; if (IFQ_Count !== 3'd0 || IF_Valid !== 1'b0 || IF_Instr !== 32'd0)
         $display("FAIL flush_post got %0d/%0b/%h want 0/0/0", IFQ_Count, IF_Valid, IF_Instr); else passed++;
      Fetch_Valid = 1'b1;
      Fetch_PC = 32'h200;
      step();
      Fetch_Valid = 1'b0;
      total++; if (IFQ_Count !== 3'd1 || IF_PC !== 32'h200)
         $display("FAIL flush_next got %0d/%h want 1/200", IFQ_Count, IF_PC); else passed++;
   endtask

   task automatic test_fields();
      logic [33:0] pres = {32'h80001000, 1'b1, 1'b0};
      do_reset();
      Fetch_Valid = 1'b1;
      Fetch_Instr = 32'h12345678;
      Fetch_PC = 32'h80000010;
      Fetch_ExceptType = 4'd3;
      Fetch_PResult = pres;
      step();
      Fetch_Valid = 1'b0;
      Fetch_Instr = '0;
      Fetch_ExceptType = '0;
      Fetch_PResult = '0;
      #1;
      total++; if (IF_ExceptType !== 4'd3) $display("FAIL fields_exc got %0d want 3", IF_ExceptType); else passed++;
      total++; if (IF_PResult !== pres) $display("FAIL fields_pred got %h want %h", IF_PResult, pres); else passed++;
      total++; if (IF_Instr !== 32'h12345678 || IF_PC !== 32'h80000010)
         $display("FAIL fields_ipc got %h/%h want 12345678/80000010", IF_Instr, IF_PC); else passed++;
   endtask

   task automatic test_random();
      logic [31:0] q[$];
      logic [31:0] next_pc = 32'h9000;
      logic        fv, wr;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         fv = ($urandom_range(0, 3) != 0);
         wr = (q.size() != 0) && ($urandom_range(0, 2) == 0);
         Fetch_Valid = fv;
         ID_Wr = wr;
         Fetch_PC = next_pc;
         #1;
         total++; if (Fetch_Ready !== (q.size() < 4)) $display("FAIL rnd_ready%0d got %0b want %0b", c, Fetch_Ready, q.size() < 4); else passed++;
         if (q.size() != 0) begin
            total++; if (IF_PC !== q[0]) $display("FAIL rnd_pc%0d got %h want %h", c, IF_PC, q[0]); else passed++;
         end
         step();
         if (fv && q.size() < 4) begin
            q.push_back(next_pc);
            next_pc += 4;
         end
         if (wr) void'(q.pop_front());
         total++; if (IFQ_Count !== 3'(q.size())) $display("FAIL rnd_cnt%0d got %0d want %0d", c, IFQ_Count, q.size()); else passed++;
      end
      Fetch_Valid = 1'b0;
      ID_Wr = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      Fetch_Valid = 1'b1;
      step();
      step();
      Fetch_Valid = 1'b0;
      total++; if (IFQ_Count !== 3'd2) $display("FAIL arst_pre got %0d want 2", IFQ_Count); else passed++;
      #2 rst = 1'b1;
      #1;
      total++; if (IF_Valid !== 1'b0 || Fetch_Ready !== 1'b1 || IFQ_Count !== 3'd0)
         $display("FAIL arst_now got %0b/%0b/%0d want 0/1/0", IF_Valid, Fetch_Ready, IFQ_Count); else passed++;
      step();
      rst = 1'b0;
      Fetch_Valid = 1'b1;
      Fetch_PC = 32'h300;
      step();
      Fetch_Valid = 1'b0;
      total++; if (IFQ_Count !== 3'd1 || IF_PC !== 32'h300)
         $display("FAIL arst_push got %0d/%h want 1/300", IFQ_Count, IF_PC); else passed++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_flush();
      test_fields();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
